adc_mon_sequencer: RTL
======================

ADC_MON_SEQUENCER -- requirements
Module: adc_mon_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 8, number of monitored mux channels (2..8).
REQ-002 SHALL have parameter SETTLE_CYC, default 4, mux settling cycles before SOC (1..15).
REQ-003 SHALL have parameter SOC_CYC, default 2, adc_soc high width in cycles (1..3).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 64, max cycles waiting on ADC per conversion.
REQ-005 SHALL have these ports; reset Reset, asynchronous, active-low; clock clk_phi1:
- clk_phi1  in  1  ADC phase-1 clock, all logic on posedge
- Reset  in  1  async active-low reset
- scan_en  in  1  continuous round-robin scan enable
- ch_mask  in  NCH  channels included in scan
- req_valid  in  1  single-shot conversion request
- req_ch  in  3  requested channel
- req_ready  out  1  request accepted this cycle when high with req_valid
- mux_sel  out  3  analog mux select
- adc_soc  out  1  start-of-conversion to ADC
- adc_eoc_b  in  1  ADC end-of-conversion, active-low
- adc_data  in  12  ADC result
- res_valid  out  1  one-cycle result strobe
- res_ch  out  3  channel of res_data
- res_data  out  12  result
- rd_ch  in  3  readback channel
- rd_data  out  12  combinational readback of last stored result for rd_ch
- busy  out  1  high whenever state is not IDLE
- timeout_err  out  1  sticky timeout flag
- err_clr  in  1  clears timeout_err

Function
REQ-006 SHALL implement FSM IDLE, SETTLE, SOC, WAIT_START, WAIT_END, STORE.
REQ-007 IDLE: req_ready=1; req_valid wins over scan; else if scan_en and ch_mask!=0, pick next set mask bit strictly after last scanned channel, wrapping NCH-1 -> 0; else stay IDLE.
REQ-008 Start: mux_sel loaded with chosen channel on leaving IDLE, held until next IDLE exit; SETTLE lasts SETTLE_CYC cycles.
REQ-009 SOC: adc_soc=1 for exactly SOC_CYC cycles, then 0; go to WAIT_START.
REQ-010 WAIT_START waits for adc_eoc_b=1 then WAIT_END waits for adc_eoc_b=0; adc_data captured the cycle adc_eoc_b=0 is seen.
REQ-011 STORE: write result to channel register, res_valid=1 for one cycle with res_ch/res_data, return IDLE.
REQ-012 Timeout counter counts cycles in WAIT_START+WAIT_END; at TIMEOUT_CYC: set timeout_err, no store, no res_valid, return IDLE; scan pointer still advances.
REQ-013 err_clr and new timeout in same cycle: set wins.
REQ-014 scan_en or ch_mask change mid-conversion: current conversion completes and stores; new value used at next IDLE decision.
REQ-015 req_ch >= NCH: accepted, converted on channel NCH-1 (clamped).
REQ-016 Minimum IDLE-to-IDLE latency, no timeout: 1+SETTLE_CYC+SOC_CYC+ADC time+1 cycles.

Reset
REQ-017 Reset low: state IDLE, mux_sel=0, adc_soc=0, res_valid=0, res_ch=0, res_data=0, timeout_err=0, busy=0, scan pointer=NCH-1 (first scan picks channel 0), all channel registers 0, counters 0.
REQ-018 Reset mid-conversion SHALL abort immediately with no res_valid and no store.

Configuration
REQ-019 Macro ADC_MON_AVG_EN defined: each channel access performs 4 conversions (SETTLE only before first), sums into 14 bits, stores sum>>2 (truncated); timeout on any one aborts the whole access.
REQ-020 ADC_MON_AVG_EN undefined: one conversion per access, adc_data stored unchanged, no accumulator logic.

Verification
REQ-021 Reset, scan_en=1, ch_mask=8'b0000_0101, ADC model returns 0x100+ch -> res_ch sequence 0,2,0,2, res_data 0x100,0x102; rd_ch=2 gives 0x102.
REQ-022 Scan running, req_valid with req_ch=5 asserted during conversion on ch0 -> req_ready low until IDLE, then ch5 converted before ch2; scan resumes at ch2.
REQ-023 adc_eoc_b stuck 1 -> timeout_err=1 after 64 WAIT cycles, no res_valid, next channel scanned; err_clr pulse clears flag.
REQ-024 Reset asserted 3 cycles into WAIT_END -> all outputs at reset values, no res_valid; after release first scan picks ch0.
REQ-025 ADC_MON_AVG_EN defined, ADC returns 0x001,0x002,0x002,0x002 on ch3 -> single res_valid, res_data=0x001 (7>>2).
REQ-026 Check adc_soc width = SOC_CYC and SETTLE_CYC cycles between mux_sel change and adc_soc rise.

Source files
------------

// File: rtl/adc_mon_sequencer.sv
// ADC mux sequencer: round-robin scan plus single-shot requests, one result register per channel.
// Define ADC_MON_AVG_EN to average four conversions per channel access.
module adc_mon_sequencer #(
  parameter int NCH         = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int SOC_CYC     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clk_phi1,
  input  logic           Reset,
  input  logic           scan_en_i,
  input  logic [NCH-1:0] ch_mask_i,
  input  logic           req_valid_i,
  input  logic [2:0]     req_ch_i,
  output logic           req_ready_o,
  output logic [2:0]     mux_sel_o,
  output logic           adc_soc_o,
  input  logic           adc_eoc_b_i,
  input  logic [11:0]    adc_data_i,
  output logic           res_valid_o,
  output logic [2:0]     res_ch_o,
  output logic [11:0]    res_data_o,
  input  logic [2:0]     rd_ch_i,
  output logic [11:0]    rd_data_o,
  output logic           busy_o,
  output logic           timeout_err_o,
  input  logic           err_clr_i
);

  localparam logic [2:0]  LAST_CH     = 3'(NCH - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0]  SOC_LAST    = 4'(SOC_CYC - 1);
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, SOC, WAIT_START, WAIT_END, STORE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  mux_q, mux_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [2:0]  res_ch_q, res_ch_d;
  logic [11:0] res_data_q, res_data_d;
  logic        err_q, err_d;
  logic        set_err;
  logic        store_en;
  logic [11:0] chan_q [8];

`ifdef ADC_MON_AVG_EN
  logic [13:0] acc_q, acc_d, sum;
  logic [1:0]  conv_q, conv_d;
`endif

  // Round-robin pick: first enabled channel strictly after the last scanned one.
  logic [7:0] mask8;
  logic       scan_hit;
  logic [2:0] scan_ch;
  int         idx;

  always_comb begin
    mask8           = '0;
    mask8[NCH-1:0]  = ch_mask_i;
    scan_hit        = 1'b0;
    scan_ch         = '0;
    idx             = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(ptr_q) + k) % NCH;
      if (!scan_hit && mask8[3'(idx)]) begin
        scan_hit = 1'b1;
        scan_ch  = 3'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mux_d       = mux_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    set_err     = 1'b0;
    store_en    = 1'b0;
    req_ready_o = 1'b0;
    adc_soc_o   = 1'b0;
    res_valid_o = 1'b0;
`ifdef ADC_MON_AVG_EN
    acc_d       = acc_q;
    conv_d      = conv_q;
    sum         = acc_q + 14'(adc_data_i);
`endif
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        cnt_d       = '0;
`ifdef ADC_MON_AVG_EN
        acc_d       = '0;
        conv_d      = '0;
`endif
        // Single-shot requests leave the scan pointer untouched.
        if (req_valid_i) begin
          mux_d   = (req_ch_i > LAST_CH) ? LAST_CH : req_ch_i;
          state_d = SETTLE;
        end else if (scan_en_i && scan_hit) begin
          mux_d   = scan_ch;
          ptr_d   = scan_ch;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = SOC;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SOC: begin
        adc_soc_o = 1'b1;
        if (cnt_q == SOC_LAST) begin
          cnt_d   = '0;
          tcnt_d  = '0;
          state_d = WAIT_START;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT_START: begin
        if (tcnt_q == TO_LAST) begin
          set_err = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
          if (adc_eoc_b_i) state_d = WAIT_END;
        end
      end
      WAIT_END: begin
        // A conversion finishing on the timeout cycle still counts as finished.
        if (!adc_eoc_b_i) begin
`ifdef ADC_MON_AVG_EN
          if (conv_q == 2'd3) begin
            res_ch_d   = mux_q;
            res_data_d = sum[13:2];
            state_d    = STORE;
          end else begin
            acc_d   = sum;
            conv_d  = conv_q + 2'd1;
            cnt_d   = '0;
            state_d = SOC;
          end
`else
          res_ch_d   = mux_q;
          res_data_d = adc_data_i;
          state_d    = STORE;
`endif
        end else if (tcnt_q == TO_LAST) begin
          set_err = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      STORE: begin
        res_valid_o = 1'b1;
        store_en    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = set_err ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clk_phi1 or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      mux_q      <= '0;
      ptr_q      <= LAST_CH;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      res_ch_q   <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
`ifdef ADC_MON_AVG_EN
      acc_q      <= '0;
      conv_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mux_q      <= mux_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
`ifdef ADC_MON_AVG_EN
      acc_q      <= acc_d;
      conv_q     <= conv_d;
`endif
    end
  end

  always_ff @(posedge clk_phi1 or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 8; i++) chan_q[i] <= '0;
    end else if (store_en) begin
      chan_q[res_ch_q] <= res_data_q;
    end
  end

  assign mux_sel_o     = mux_q;
  assign res_ch_o      = res_ch_q;
  assign res_data_o    = res_data_q;
  assign rd_data_o     = chan_q[rd_ch_i];
  assign busy_o        = (state_q != IDLE);
  assign timeout_err_o = err_q;

endmodule
